// File: rtl/sap_pkg.sv
// sap_pkg: shared constants for the SAP control sequencer.
//   - 4-bit opcode values (decoded from the low nibble of the IR)
//   - alu_op encodings
//   - one-hot T-state constants and the HALT encoding (all zeros)
//   - alu_code(): maps an ALU/CMP opcode to its alu_op encoding
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_CMP = 4'd6;
  localparam logic [3:0] OP_JMP = 4'd7;
  localparam logic [3:0] OP_JZ  = 4'd8;
  localparam logic [3:0] OP_NOP = 4'd9;  // canonical NOP used for undecodable opcodes
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;
  localparam logic [2:0] ALU_CMP = 3'd5;  // ALU computes SUB; only flags are kept

  localparam logic [5:0] T1     = 6'b000001;
  localparam logic [5:0] T2     = 6'b000010;
  localparam logic [5:0] T3     = 6'b000100;
  localparam logic [5:0] T4     = 6'b001000;
  localparam logic [5:0] T5     = 6'b010000;
  localparam logic [5:0] T6     = 6'b100000;
  localparam logic [5:0] T_HALT = 6'b000000;

  function automatic logic [2:0] alu_code(input logic [3:0] op);
    case (op)
      OP_SUB:  alu_code = ALU_SUB;
      OP_XOR:  alu_code = ALU_XOR;
      OP_AND:  alu_code = ALU_AND;
      OP_OR:   alu_code = ALU_OR;
      OP_CMP:  alu_code = ALU_CMP;
      default: alu_code = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// sap_ring_counter: 6-stage one-hot T-state ring.
// Ports:
//   clk, clr     clock / async active-high clear (back to T1, halted=0)
//   en           advance one T-state per cycle when high
//   wrap         synchronous early return to T1 (sampled only with en)
//   halt         enter HALT (t_state=0, halted=1); only clr leaves it
//   t_state      one-hot T-state, 0 in HALT
//   halted       registered halt state
module sap_ring_counter
  import sap_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       wrap,
  input  logic       halt,
  output logic [5:0] t_state,
  output logic       halted
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      t_state <= T1;
      halted  <= 1'b0;
    end else if (en && !halted) begin
      if (halt) begin
        t_state <= T_HALT;
        halted  <= 1'b1;
      end else if (wrap) begin
        t_state <= T1;
      end else begin
        // plain rotate: T6 naturally wraps to T1
        t_state <= {t_state[4:0], t_state[5]};
      end
    end
  end

endmodule

// File: rtl/sap_control_sequencer.sv
// sap_control_sequencer: T-state ring + microcode decode for the SAP CPU.
// Parameters: OP_W (opcode width, >=4), SKIP_IDLE (early return to T1).
// Optional feature macro: SAP_JUMP_EN enables JMP/JZ; otherwise opcodes 7/8
// are NOPs and pc_ld is never asserted.
// Ports:
//   clk, clr            clock / async active-high clear
//   run                 advance enable; when low state holds, strobes are 0
//   op_code, zero_flag  IR opcode (used in T4-T6), ALU zero flag (JZ T4)
//   t_state, halted     one-hot T-state (0 in HALT) and halt indicator
//   pc_out..out_ld      one-cycle datapath strobes
//   alu_op              ALU function, nonzero only in ALU/CMP T6
module sap_control_sequencer
  import sap_pkg::*;
#(
  parameter int OP_W      = 4,
  parameter bit SKIP_IDLE = 1'b1
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            run,
  input  logic [OP_W-1:0] op_code,
  input  logic            zero_flag,
  output logic [5:0]      t_state,
  output logic            halted,
  output logic            pc_out,
  output logic            pc_inc,
  output logic            pc_ld,
  output logic            mar_ld,
  output logic            mem_rd,
  output logic            ir_ld,
  output logic            ir_out,
  output logic            acc_ld,
  output logic            acc_out,
  output logic            b_ld,
  output logic            alu_out,
  output logic            flag_ld,
  output logic            out_ld,
  output logic [2:0]      alu_op
);

  logic       active, wrap, halt_req;
  logic [3:0] op;
  logic       is_lda, is_alu, is_cmp, is_out, is_jmp, is_jz, is_hlt, is_short;

  // clr gates strobes too, so nothing fires while reset is held
  assign active = run & ~clr & ~halted;

  // any set bit above the decoded nibble makes the opcode a NOP
  assign op = ((op_code >> 4) != '0) ? OP_NOP : op_code[3:0];

  assign is_lda = (op == OP_LDA);
  assign is_alu = (op >= OP_ADD) && (op <= OP_CMP);
  assign is_cmp = (op == OP_CMP);
  assign is_out = (op == OP_OUT);
  assign is_hlt = (op == OP_HLT);
`ifdef SAP_JUMP_EN
  assign is_jmp = (op == OP_JMP);
  assign is_jz  = (op == OP_JZ);
`else
  logic unused_zero_flag;
  assign is_jmp = 1'b0;
  assign is_jz  = 1'b0;
  assign unused_zero_flag = zero_flag;
`endif
  // everything finishing at T4: OUT, jumps and all NOP-decoded opcodes
  assign is_short = ~(is_lda | is_alu | is_hlt);

  always_comb begin
    pc_out = 1'b0; pc_inc = 1'b0; pc_ld  = 1'b0; mar_ld  = 1'b0;
    mem_rd = 1'b0; ir_ld  = 1'b0; ir_out = 1'b0; acc_ld  = 1'b0;
    acc_out = 1'b0; b_ld  = 1'b0; alu_out = 1'b0; flag_ld = 1'b0;
    out_ld = 1'b0; alu_op = ALU_ADD; wrap = 1'b0; halt_req = 1'b0;
    if (active) begin
      case (t_state)
        T1: begin pc_out = 1'b1; mar_ld = 1'b1; end
        T2: pc_inc = 1'b1;
        T3: begin mem_rd = 1'b1; ir_ld = 1'b1; end
        T4: begin
          if (is_lda || is_alu) begin ir_out = 1'b1; mar_ld = 1'b1; end
          if (is_out) begin acc_out = 1'b1; out_ld = 1'b1; end
`ifdef SAP_JUMP_EN
          if (is_jmp) begin ir_out = 1'b1; pc_ld = 1'b1; end
          if (is_jz)  begin ir_out = 1'b1; pc_ld = zero_flag; end
`endif
          halt_req = is_hlt;
          wrap     = SKIP_IDLE && is_short;
        end
        T5: begin
          if (is_lda) begin mem_rd = 1'b1; acc_ld = 1'b1; wrap = SKIP_IDLE; end
          if (is_alu) begin mem_rd = 1'b1; b_ld = 1'b1; end
        end
        T6: begin
          if (is_alu) begin
            flag_ld = 1'b1;
            alu_op  = alu_code(op);
            alu_out = ~is_cmp;
            acc_ld  = ~is_cmp;
          end
        end
        default: ;
      endcase
    end
  end

  sap_ring_counter u_ring (
    .clk     (clk),
    .clr     (clr),
    .en      (run),
    .wrap    (wrap),
    .halt    (halt_req),
    .t_state (t_state),
    .halted  (halted)
  );

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Scoreboard bench: the driver applies one input vector per cycle just after
// the rising edge and queues the hand-computed expected outputs; the monitor
// pops on the falling edge and compares. Two instances: SKIP_IDLE=1 (dut 0)
// and SKIP_IDLE=0 (dut 1), sharing all inputs.
module tb_sap_control_sequencer;
  import sap_pkg::*;

  localparam logic [12:0] PC_OUT = 13'h1000, PC_INC = 13'h0800, PC_LD   = 13'h0400;
  localparam logic [12:0] MAR_LD = 13'h0200, MEM_RD = 13'h0100, IR_LD   = 13'h0080;
  localparam logic [12:0] IR_OUT = 13'h0040, ACC_LD = 13'h0020, ACC_OUT = 13'h0010;
  localparam logic [12:0] B_LD   = 13'h0008, ALU_OUT = 13'h0004, FLAG_LD = 13'h0002;
  localparam logic [12:0] OUT_LD = 13'h0001, NONE = 13'h0000;
`ifdef SAP_JUMP_EN
  localparam bit JEN = 1'b1;
`else
  localparam bit JEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr = 1'b1, run = 1'b0, zero_flag = 1'b0;
  logic [3:0] op_code = 4'd0;
  always #5 clk = ~clk;

  logic [5:0]  t_a, t_b;
  logic        h_a, h_b;
  logic [2:0]  alu_a, alu_b;
  logic [12:0] s_a, s_b;

  sap_control_sequencer #(.OP_W(4), .SKIP_IDLE(1'b1)) dut_a (
    .clk(clk), .clr(clr), .run(run), .op_code(op_code), .zero_flag(zero_flag),
    .t_state(t_a), .halted(h_a),
    .pc_out(s_a[12]), .pc_inc(s_a[11]), .pc_ld(s_a[10]), .mar_ld(s_a[9]),
    .mem_rd(s_a[8]), .ir_ld(s_a[7]), .ir_out(s_a[6]), .acc_ld(s_a[5]),
    .acc_out(s_a[4]), .b_ld(s_a[3]), .alu_out(s_a[2]), .flag_ld(s_a[1]),
    .out_ld(s_a[0]), .alu_op(alu_a));

  sap_control_sequencer #(.OP_W(4), .SKIP_IDLE(1'b0)) dut_b (
    .clk(clk), .clr(clr), .run(run), .op_code(op_code), .zero_flag(zero_flag),
    .t_state(t_b), .halted(h_b),
    .pc_out(s_b[12]), .pc_inc(s_b[11]), .pc_ld(s_b[10]), .mar_ld(s_b[9]),
    .mem_rd(s_b[8]), .ir_ld(s_b[7]), .ir_out(s_b[6]), .acc_ld(s_b[5]),
    .acc_out(s_b[4]), .b_ld(s_b[3]), .alu_out(s_b[2]), .flag_ld(s_b[1]),
    .out_ld(s_b[0]), .alu_op(alu_b));

  typedef struct {
    logic        d;
    int          id;
    logic [5:0]  t;
    logic        h;
    logic [12:0] s;
    logic [2:0]  a;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0, nid = 0;

  // one cycle: apply inputs, optionally queue expected outputs for dut d
  task automatic cyc(input logic c, input logic r, input logic [3:0] op,
                     input logic zf, input logic chk, input logic d,
                     input logic [5:0] t, input logic h,
                     input logic [12:0] s, input logic [2:0] a);
    exp_t e;
    @(posedge clk);
    #1;
    clr = c; run = r; op_code = op; zero_flag = zf;
    if (chk) begin
      e.d = d; e.id = nid; e.t = t; e.h = h; e.s = s; e.a = a;
      q.push_back(e);
      nid++;
    end
  endtask

  task automatic fetch(input logic d, input logic [3:0] op);
    cyc(0, 1, op, 0, 1, d, T1, 0, PC_OUT | MAR_LD, 3'd0);
    cyc(0, 1, op, 0, 1, d, T2, 0, PC_INC, 3'd0);
    cyc(0, 1, op, 0, 1, d, T3, 0, MEM_RD | IR_LD, 3'd0);
  endtask

  task automatic ex(input logic d, input logic [3:0] op, input logic zf,
                    input logic [5:0] t, input logic [12:0] s, input logic [2:0] a);
    cyc(0, 1, op, zf, 1, d, t, 0, s, a);
  endtask

  task automatic alu_instr(input logic [3:0] op, input logic [3:0] fop,
                           input logic [12:0] s6, input logic [2:0] a6);
    fetch(0, fop);
    ex(0, op, 0, T4, IR_OUT | MAR_LD, 3'd0);
    ex(0, op, 0, T5, MEM_RD | B_LD, 3'd0);
    ex(0, op, 0, T6, s6, a6);
  endtask

  // monitor
  initial begin
    exp_t e;
    logic [5:0] gt; logic gh; logic [12:0] gs; logic [2:0] ga;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        gt = e.d ? t_b : t_a;  gh = e.d ? h_b : h_a;
        gs = e.d ? s_b : s_a;  ga = e.d ? alu_b : alu_a;
        checks++;
        if (gt !== e.t || gh !== e.h || gs !== e.s || ga !== e.a) begin
          errors++;
          $display("FAIL step%0d dut%0d: got t=%b h=%b s=%b alu=%0d, expected t=%b h=%b s=%b alu=%0d",
                   e.id, e.d, gt, gh, gs, ga, e.t, e.h, e.s, e.a);
        end
      end
    end
  end

  initial begin
    // reset held, run low then high: T1, nothing strobed
    cyc(1, 0, 4'd0, 0, 1, 0, T1, 0, NONE, 3'd0);
    cyc(1, 1, 4'd1, 0, 1, 0, T1, 0, NONE, 3'd0);
    // ADD, SUB, CMP (opcode garbage during fetch), OR
    alu_instr(OP_ADD, OP_ADD, ALU_OUT | ACC_LD | FLAG_LD, 3'd0);
    alu_instr(OP_SUB, OP_SUB, ALU_OUT | ACC_LD | FLAG_LD, 3'd1);
    alu_instr(OP_CMP, OP_HLT, FLAG_LD, 3'd5);
    alu_instr(OP_OR,  OP_OR,  ALU_OUT | ACC_LD | FLAG_LD, 3'd4);
    // LDA with run dropped in T5, then early wrap after T5
    fetch(0, OP_LDA);
    ex(0, OP_LDA, 0, T4, IR_OUT | MAR_LD, 3'd0);
    for (int i = 0; i < 3; i++) cyc(0, 0, OP_LDA, 0, 1, 0, T5, 0, NONE, 3'd0);
    ex(0, OP_LDA, 0, T5, MEM_RD | ACC_LD, 3'd0);
    // OUT: early wrap after T4
    fetch(0, OP_OUT);
    ex(0, OP_OUT, 0, T4, ACC_OUT | OUT_LD, 3'd0);
    // JZ not taken / taken, JMP, NOP
    fetch(0, OP_JZ);
    ex(0, OP_JZ, 0, T4, JEN ? IR_OUT : NONE, 3'd0);
    fetch(0, OP_JZ);
    ex(0, OP_JZ, 1, T4, JEN ? (IR_OUT | PC_LD) : NONE, 3'd0);
    fetch(0, OP_JMP);
    ex(0, OP_JMP, 0, T4, JEN ? (IR_OUT | PC_LD) : NONE, 3'd0);
    fetch(0, 4'd10);
    ex(0, 4'd10, 0, T4, NONE, 3'd0);
    // clr while in T3 returns to T1 immediately
    cyc(0, 1, OP_ADD, 0, 1, 0, T1, 0, PC_OUT | MAR_LD, 3'd0);
    cyc(0, 1, OP_ADD, 0, 1, 0, T2, 0, PC_INC, 3'd0);
    cyc(1, 1, OP_ADD, 0, 1, 0, T1, 0, NONE, 3'd0);
    // HLT: T4 silent, then HALT for 20 cycles regardless of inputs
    fetch(0, OP_HLT);
    ex(0, OP_HLT, 0, T4, NONE, 3'd0);
    for (int i = 0; i < 20; i++)
      cyc(0, 1, 4'(i), i[0], 1, 0, T_HALT, 1, NONE, 3'd0);
    cyc(1, 1, OP_HLT, 0, 1, 0, T1, 0, NONE, 3'd0);
    // SKIP_IDLE=0 instance: OUT and LDA both run to T6 with idle states
    fetch(1, OP_OUT);
    ex(1, OP_OUT, 0, T4, ACC_OUT | OUT_LD, 3'd0);
    ex(1, OP_OUT, 0, T5, NONE, 3'd0);
    ex(1, OP_OUT, 0, T6, NONE, 3'd0);
    fetch(1, OP_LDA);
    ex(1, OP_LDA, 0, T4, IR_OUT | MAR_LD, 3'd0);
    ex(1, OP_LDA, 0, T5, MEM_RD | ACC_LD, 3'd0);
    ex(1, OP_LDA, 0, T6, NONE, 3'd0);
    cyc(0, 1, OP_LDA, 0, 1, 1, T1, 0, PC_OUT | MAR_LD, 3'd0);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sap_control_sequencer.md
# sap_control_sequencer

Parametrised control sequencer for the SAP CPU. It replaces the flat combinational opcode decoder with a T-state ring counter and a microcode decode stage, so the CPU fetches and executes autonomously. It sits between the instruction register (supplies `op_code`) and the datapath registers, ALU and memory, which it drives with one-cycle control strobes. It adds run/step gating, a registered halt state, early instruction termination and optional jumps.

## Interface
- `OP_W`, 4: opcode width (>= 4). Only the low 4 bits are decoded; any nonzero upper bit decodes as NOP.
- `SKIP_IDLE`, 1: when 1, an instruction with no remaining micro-ops returns to T1 early. When 0, every instruction takes 6 T-states.
- `clk`  in  1  system clock. All state changes on rising edge.
- `clr`  in  1  asynchronous, active-high reset.
- `run`  in  1  advance enable. When 0, state is held and all strobes are 0.
- `op_code`  in  OP_W  opcode from the IR. Valid from T4.
- `zero_flag`  in  1  ALU zero flag. Used only by JZ.
- `t_state`  out  6  one-hot current T-state. T1 = 6'b000001.
- `halted`  out  1  high while in HALT.
- `pc_out`, `pc_inc`, `pc_ld`, `mar_ld`, `mem_rd`, `ir_ld`, `ir_out`, `acc_ld`, `acc_out`, `b_ld`, `alu_out`, `flag_ld`, `out_ld`  out  1 each  datapath strobes, active-high.
- `alu_op`  out  3  ALU function: ADD=0, SUB=1, XOR=2, AND=3, OR=4, CMP=5 (CMP computes SUB).

## Operation
- Opcodes: LDA 0, ADD 1, SUB 2, XOR 3, AND 4, OR 5, CMP 6, JMP 7, JZ 8, OUT 14, HLT 15. All others are NOP.
- Fetch, common to all opcodes:
  - T1: `pc_out`, `mar_ld`
  - T2: `pc_inc`
  - T3: `mem_rd`, `ir_ld`
- Execute phase:
  - LDA:
    - T4: `ir_out`, `mar_ld`
    - T5: `mem_rd`, `acc_ld`
    - T6: idle
  - ADD/SUB/XOR/AND/OR:
    - T4: `ir_out`, `mar_ld`
    - T5: `mem_rd`, `b_ld`
    - T6: `alu_out`, `acc_ld`, `flag_ld`, and `alu_op` per opcode
  - CMP: same as the ALU ops, except T6 asserts only `flag_ld` with `alu_op`=5. Accumulator unchanged.
  - OUT:
    - T4: `acc_out`, `out_ld`
    - T5, T6: idle
  - JMP: T4 `ir_out`, `pc_ld`.
  - JZ: T4 `ir_out`, plus `pc_ld` only if `zero_flag`=1.
  - NOP: T4–T6 idle.
  - HLT: T4 asserts no strobe. The next state is HALT (`t_state`=0, `halted`=1). HALT is left only by `clr`.
- Early termination (SKIP_IDLE=1): after the last active T-state, go to T1.
  - LDA: after T5.
  - OUT, JMP, JZ, NOP: after T4.
- Strobes are combinational from the registered state and `op_code`, gated by `run`. They are never asserted in HALT or during `clr`.
- `alu_op` is 0 whenever no ALU/CMP T6 is active.

## Timing
- Reset while `clr`=1: `t_state`=000001, `halted`=0, all strobes and `alu_op` forced to 0. First active T1 strobes appear in the cycle after `clr` falls, provided `run`=1.
- Each T-state lasts exactly one cycle while `run`=1.
- Instruction latency:
  - ALU/CMP: 6 cycles.
  - LDA: 5 cycles (SKIP_IDLE=1), else 6.
  - OUT/JMP/JZ/NOP: 4 cycles (SKIP_IDLE=1), else 6.
- `run` dropping mid-instruction: freeze at the current T-state with strobes 0. Resume at the same T-state when `run` returns.
- `clr` mid-instruction, including in HALT: immediate return to T1, `halted`=0.
- `op_code` is sampled combinationally in T4–T6 only. Changes during T1–T3 have no effect.
- `zero_flag` is sampled in the JZ T4 cycle only.

## Configuration
- `SAP_JUMP_EN` defined: JMP and JZ behave as specified.
- `SAP_JUMP_EN` undefined: opcodes 7 and 8 decode as NOP, and `pc_ld` is tied 0.

## Structure
- Package `sap_pkg`:
  - opcode localparams
  - `alu_op` encodings
  - T-state one-hot constants
  - HALT encoding
- Sub-module `sap_ring_counter`: 6-stage one-hot ring with enable, synchronous early-wrap input, halt input, and async `clr`.
- The decode/strobe logic stays in `sap_control_sequencer`.

## Test plan
- Reset, then `run`=1, `op_code`=1 (ADD): `t_state` cycles 1,2,4,8,16,32. T6 shows `alu_out`=`acc_ld`=`flag_ld`=1 and `alu_op`=0. `t_state` then returns to 1.
- `op_code`=6 (CMP) in T6: `flag_ld`=1, `alu_op`=5, `acc_ld`=0.
- SKIP_IDLE=1, `op_code`=14 (OUT): T4 has `acc_out`=`out_ld`=1; next `t_state`=1. Repeat with SKIP_IDLE=0: idle T5 and T6 precede T1.
- `op_code`=15 (HLT): after T4, `halted`=1 and `t_state`=0, with strobes 0 for 20 cycles. Pulse `clr`: `t_state`=1, `halted`=0.
- `SAP_JUMP_EN` defined, `op_code`=8:
  - `zero_flag`=0: `pc_ld`=0 at T4.
  - `zero_flag`=1: `pc_ld`=1 at T4.
  - Without the macro: `pc_ld`=0 in both cases.
- `run` dropped at T5 of an LDA for 3 cycles: `t_state` holds 16 with strobes 0. On resume, `mem_rd`=`acc_ld`=1. Asserting `clr` at T3 returns to T1 immediately.
